// File: rtl/decode_stage_if.sv
// decode_stage_if: upstream/downstream handshake and decoded-field bundle for decode_stage
interface decode_stage_if #(parameter int XLEN = 64);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [XLEN-1:0] in_pc, out_pc, imm;
  logic [4:0] rd, rs1, rs2, alu_op;
  logic need_imm, rd_wen, is_load, is_store, is_branch, is_jump, word_op, is_ebreak, illegal;
  modport master(
    output in_valid, in_inst, in_pc, out_ready,
    input in_ready, out_valid, out_pc, imm, rd, rs1, rs2, alu_op,
    input need_imm, rd_wen, is_load, is_store, is_branch, is_jump, word_op, is_ebreak, illegal
  );
  modport slave(
    input in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, imm, rd, rs1, rs2, alu_op,
    output need_imm, rd_wen, is_load, is_store, is_branch, is_jump, word_op, is_ebreak, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV64I decoder with one registered output stage and halt-on-EBREAK/illegal.
// Define DECODE_MEXT_EN to decode the M extension; otherwise those encodings are illegal.
module decode_stage #(parameter int XLEN = 64) (
  input logic clk,
  input logic rst,
  input logic flush,
  decode_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FULL, HALT_PEND, HALTED} state_t;
  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J} fmt_t;
  localparam int W = 2 * XLEN + 29;
  localparam bit RV64 = XLEN == 64;
`ifdef DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  function automatic logic [4:0] alu_of(input logic [2:0] f, input logic a);
    case (f)
      3'b000: alu_of = a ? 5'd1 : 5'd0;
      3'b001: alu_of = 5'd2;
      3'b010: alu_of = 5'd3;
      3'b011: alu_of = 5'd4;
      3'b100: alu_of = 5'd5;
      3'b101: alu_of = a ? 5'd7 : 5'd6;
      3'b110: alu_of = 5'd8;
      default: alu_of = 5'd9;
    endcase
  endfunction
  logic [31:0] inst, imm32;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic alt, mul, sh_ok, op_ok, op32_ok, sh7_ok;
  fmt_t fmt;
  logic ok, ld, st, br, jp, wop, eb, halt, wen, need, take;
  logic [4:0] op, rd_x, rs1_x, rs2_x;
  logic [XLEN-1:0] imm_x;
  logic [W-1:0] d, q;
  state_t state, nxt;
  assign inst = bus.in_inst;
  assign opc = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign alt = inst[30];
  assign mul = f7 == 7'b0000001;
  assign sh7_ok = (f7 & 7'b1011111) == 7'd0;
  // RV64 shifts carry a 6-bit shamt, so only inst[31:26] is the function field
  assign sh_ok = (RV64 ? (inst[31:26] & 6'b101111) == 6'd0 : sh7_ok) && (!alt || f3[2]);
  assign op_ok = f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
  assign op32_ok = f7 == 7'd0 ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5) : op_ok;
  always_comb begin
    fmt = F_I;
    ok = 1'b0;
    op = 5'd0;
    ld = 1'b0;
    st = 1'b0;
    br = 1'b0;
    jp = 1'b0;
    wop = 1'b0;
    eb = 1'b0;
    case (opc)
      7'b0010011: begin
        ok = f3[1:0] != 2'b01 || sh_ok;
        op = alu_of(f3, f3 == 3'd5 && alt);
      end
      7'b0110011: begin
        fmt = F_R;
        ok = mul ? MEXT : op_ok;
        op = mul ? 5'd11 + {2'b00, f3} : alu_of(f3, alt);
      end
      7'b0011011: begin
        ok = RV64 && (f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'd0) || (f3 == 3'd5 && sh7_ok));
        op = alu_of(f3, f3 == 3'd5 && alt);
        wop = 1'b1;
      end
      7'b0111011: begin
        fmt = F_R;
        ok = RV64 && (mul ? MEXT && (f3 == 3'd0 || f3[2]) : op32_ok);
        op = mul ? 5'd11 + {2'b00, f3} : alu_of(f3, alt);
        wop = 1'b1;
      end
      7'b0110111: begin
        fmt = F_U;
        ok = 1'b1;
        op = 5'd10;
      end
      7'b0010111: begin
        fmt = F_U;
        ok = 1'b1;
      end
      7'b1101111: begin
        fmt = F_J;
        ok = 1'b1;
        jp = 1'b1;
      end
      7'b1100111: begin
        ok = f3 == 3'd0;
        jp = 1'b1;
      end
      7'b1100011: begin
        fmt = F_B;
        ok = f3[2:1] != 2'b01;
        br = 1'b1;
        op = f3[2] ? (f3[1] ? 5'd4 : 5'd3) : 5'd1;
      end
      7'b0000011: begin
        ok = RV64 ? f3 != 3'd7 : (f3 != 3'd3 && f3 < 3'd6);
        ld = 1'b1;
      end
      7'b0100011: begin
        fmt = F_S;
        ok = RV64 ? !f3[2] : f3 < 3'd3;
        st = 1'b1;
      end
      7'b1110011: begin
        ok = inst == 32'h0000_0073 || inst == 32'h0010_0073;
        eb = inst[20];
      end
      default: ;
    endcase
  end
  always_comb begin
    imm32 = fmt == F_I ? {{20{inst[31]}}, inst[31:20]} :
            fmt == F_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
            fmt == F_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
            fmt == F_U ? {inst[31:12], 12'd0} :
            fmt == F_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : 32'd0;
    imm_x = ok ? XLEN'($signed(imm32)) : '0;
    rd_x = ok && fmt != F_S && fmt != F_B ? inst[11:7] : 5'd0;
    rs1_x = ok && fmt != F_U && fmt != F_J ? inst[19:15] : 5'd0;
    rs2_x = ok && (fmt == F_R || fmt == F_S || fmt == F_B) ? inst[24:20] : 5'd0;
    wen = rd_x != 5'd0;
    need = ok && fmt != F_R;
    halt = !ok || eb;
  end
  assign d = {bus.in_pc, imm_x, rd_x, rs1_x, rs2_x, ok ? op : 5'd0, need, wen,
              ld & ok, st & ok, br & ok, jp & ok, wop & ok, eb & ok, !ok};
  assign {bus.out_pc, bus.imm, bus.rd, bus.rs1, bus.rs2, bus.alu_op, bus.need_imm, bus.rd_wen,
          bus.is_load, bus.is_store, bus.is_branch, bus.is_jump, bus.word_op, bus.is_ebreak,
          bus.illegal} = q;
  assign take = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else state <= nxt;
  end
  always_comb begin
    nxt = flush ? EMPTY :
          state == HALTED ? HALTED :
          state == HALT_PEND ? (bus.out_ready ? HALTED : HALT_PEND) :
          take ? (halt ? HALT_PEND : FULL) :
          state == FULL && !bus.out_ready ? FULL : EMPTY;
  end
  always_comb begin
    bus.in_ready = state == EMPTY || (state == FULL && bus.out_ready);
    bus.out_valid = state == FULL || state == HALT_PEND;
  end
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (take && !flush) q <= d;
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode vectors plus handshake/halt/flush/reset sequences
module tb_decode_stage;
  typedef struct {
    logic [31:0] inst;
    logic [4:0] rd, rs1, rs2, op;
    logic [63:0] imm;
    logic [8:0] fl;
  } vec_t;
  localparam int N = 20;
  logic clk = 1'b0, rst, flush;
  int total = 0, bad = 0;
  vec_t tbl[N];
  logic [8:0] flags;
  logic [63:0] pc;
  logic halt;
  always #5 clk = ~clk;
  decode_stage_if #(.XLEN(64)) bus();
  decode_stage #(.XLEN(64)) dut(.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  assign flags = {bus.need_imm, bus.rd_wen, bus.is_load, bus.is_store, bus.is_branch,
                  bus.is_jump, bus.word_op, bus.is_ebreak, bus.illegal};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] inst, input logic [63:0] p);
    bus.in_valid = 1'b1;
    bus.in_inst = inst;
    bus.in_pc = p;
  endtask
  initial begin
    tbl[0]  = '{32'hFFF00093, 5'd1, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 9'h180};
    tbl[1]  = '{32'hFE000EE3, 5'd0, 5'd0, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC, 9'h110};
    tbl[2]  = '{32'h002081B3, 5'd3, 5'd1, 5'd2, 5'd0, 64'h0, 9'h080};
    tbl[3]  = '{32'h407302B3, 5'd5, 5'd6, 5'd7, 5'd1, 64'h0, 9'h080};
    tbl[4]  = '{32'h12345537, 5'd10, 5'd0, 5'd0, 5'd10, 64'h1234_5000, 9'h180};
    tbl[5]  = '{32'h80000537, 5'd10, 5'd0, 5'd0, 5'd10, 64'hFFFF_FFFF_8000_0000, 9'h180};
    tbl[6]  = '{32'h00813203, 5'd4, 5'd2, 5'd0, 5'd0, 64'h8, 9'h1C0};
    tbl[7]  = '{32'hFE532E23, 5'd0, 5'd6, 5'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 9'h120};
    tbl[8]  = '{32'h001000EF, 5'd1, 5'd0, 5'd0, 5'd0, 64'h800, 9'h188};
    tbl[9]  = '{32'h00008067, 5'd0, 5'd1, 5'd0, 5'd0, 64'h0, 9'h108};
    tbl[10] = '{32'h42115093, 5'd1, 5'd2, 5'd0, 5'd7, 64'h421, 9'h180};
    tbl[11] = '{32'h002081BB, 5'd3, 5'd1, 5'd2, 5'd0, 64'h0, 9'h084};
    tbl[12] = '{32'hFFFFF117, 5'd2, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F000, 9'h180};
    tbl[13] = '{32'h0020E463, 5'd0, 5'd1, 5'd2, 5'd4, 64'h8, 9'h110};
    tbl[14] = '{32'h00100073, 5'd0, 5'd0, 5'd0, 5'd0, 64'h1, 9'h102};
    tbl[15] = '{32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 5'd0, 64'h0, 9'h001};
`ifdef DECODE_MEXT_EN
    tbl[16] = '{32'h022081B3, 5'd3, 5'd1, 5'd2, 5'd11, 64'h0, 9'h080};
`else
    tbl[16] = '{32'h022081B3, 5'd0, 5'd0, 5'd0, 5'd0, 64'h0, 9'h001};
`endif
    tbl[17] = '{32'h00000073, 5'd0, 5'd0, 5'd0, 5'd0, 64'h0, 9'h100};
    tbl[18] = '{32'h0000000F, 5'd0, 5'd0, 5'd0, 5'd0, 64'h0, 9'h001};
    tbl[19] = '{32'hFFF0809B, 5'd1, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 9'h184};
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_inst = 32'd0;
    bus.in_pc = 64'd0;
    bus.out_ready = 1'b1;
    tick;
    tick;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst out_pc", bus.out_pc, 0);
    chk("rst imm", bus.imm, 0);
    chk("rst flags", flags, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      pc = 64'h1000 + 64'(i) * 4;
      halt = tbl[i].fl[1] | tbl[i].fl[0];
      send(tbl[i].inst, pc);
      tick;
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d rd", i), bus.rd, tbl[i].rd);
      chk($sformatf("v%0d rs1", i), bus.rs1, tbl[i].rs1);
      chk($sformatf("v%0d rs2", i), bus.rs2, tbl[i].rs2);
      chk($sformatf("v%0d alu_op", i), bus.alu_op, tbl[i].op);
      chk($sformatf("v%0d imm", i), bus.imm, tbl[i].imm);
      chk($sformatf("v%0d flags", i), flags, tbl[i].fl);
      chk($sformatf("v%0d out_pc", i), bus.out_pc, pc);
      chk($sformatf("v%0d in_ready", i), bus.in_ready, !halt);
      tick;
      chk($sformatf("v%0d drained", i), bus.out_valid, 0);
      chk($sformatf("v%0d in_ready after", i), bus.in_ready, !halt);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk($sformatf("v%0d in_ready post flush", i), bus.in_ready, 1);
    end
    bus.out_ready = 1'b0;
    send(tbl[2].inst, 64'h2000);
    tick;
    send(tbl[3].inst, 64'h2004);
    for (int k = 0; k < 3; k++) begin
      chk("stall rd", bus.rd, 3);
      chk("stall pc", bus.out_pc, 64'h2000);
      chk("stall in_ready", bus.in_ready, 0);
      chk("stall out_valid", bus.out_valid, 1);
      tick;
    end
    bus.out_ready = 1'b1;
    chk("release first rd", bus.rd, 3);
    tick;
    bus.in_valid = 1'b0;
    chk("release second valid", bus.out_valid, 1);
    chk("release second rd", bus.rd, 5);
    chk("release second pc", bus.out_pc, 64'h2004);
    tick;
    chk("release drained", bus.out_valid, 0);
    for (int j = 2; j < 6; j++) begin
      send(tbl[j].inst, 64'h2100 + 64'(j));
      tick;
      chk("b2b valid", bus.out_valid, 1);
      chk("b2b rd", bus.rd, tbl[j].rd);
      chk("b2b pc", bus.out_pc, 64'h2100 + 64'(j));
      chk("b2b in_ready", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
    tick;
    chk("b2b drained", bus.out_valid, 0);
    send(tbl[2].inst, 64'h2200);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush drops transfer", bus.out_valid, 0);
    chk("flush in_ready", bus.in_ready, 1);
    send(tbl[0].inst, 64'h3000);
    tick;
    send(tbl[4].inst, 64'h3004);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst full out_valid", bus.out_valid, 0);
    chk("rst full rd", bus.rd, 0);
    chk("rst full pc", bus.out_pc, 0);
    chk("rst full imm", bus.imm, 0);
    chk("rst full flags", flags, 0);
    chk("rst full alu_op", bus.alu_op, 0);
    bus.out_ready = 1'b0;
    send(tbl[14].inst, 64'h4000);
    tick;
    bus.in_valid = 1'b0;
    chk("hp out_valid", bus.out_valid, 1);
    chk("hp in_ready", bus.in_ready, 0);
    chk("hp ebreak", bus.is_ebreak, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("hp rst out_valid", bus.out_valid, 0);
    chk("hp rst in_ready", bus.in_ready, 1);
    chk("hp rst flags", flags, 0);
    bus.out_ready = 1'b1;
    tick;
    chk("hp rst no leftover", bus.out_valid, 0);
    send(tbl[15].inst, 64'h5000);
    tick;
    send(tbl[2].inst, 64'h5004);
    chk("ill hp valid", bus.out_valid, 1);
    chk("ill hp illegal", bus.illegal, 1);
    tick;
    for (int k = 0; k < 3; k++) begin
      chk("halted out_valid", bus.out_valid, 0);
      chk("halted in_ready", bus.in_ready, 0);
      tick;
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("unhalt in_ready", bus.in_ready, 1);
    tick;
    bus.in_valid = 1'b0;
    chk("unhalt valid", bus.out_valid, 1);
    chk("unhalt rd", bus.rd, 3);
    chk("unhalt pc", bus.out_pc, 64'h5004);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
